bcd_convert_arbiter: RTL

Shared, multi-cycle hex-to-BCD conversion engine with round-robin arbitration between several requesters (score counters, mouse-coordinate readouts) that each need decimal digits for the seven-segment/VGA digit path. It replaces one combinational double-dabble converter per display source with a single serial converter: one shift-and-correct step per clock, one result register, and a req/ack handshake per requester.

---
 rtl/bcd_convert_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/bcd_convert_arbiter.sv
// Shared serial hex-to-BCD converter (double dabble, one step per clock)
// with round-robin arbitration and per-requester ack pulses.
module bcd_convert_arbiter #(
    parameter  int NUM_REQ     = 4,
    parameter  int NIBBLE_SIZE = 2,
    localparam int BCD_SIZE    = (NIBBLE_SIZE < 5) ? (NIBBLE_SIZE + 1) * 4 :
                                 (NIBBLE_SIZE < 10) ? (NIBBLE_SIZE + 2) * 4 :
                                 (NIBBLE_SIZE + 3) * 4,
    localparam int W           = 4 * NIBBLE_SIZE,
    localparam int GW          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] hexValue,
    output logic [NUM_REQ-1:0]   ack,
    output logic [BCD_SIZE-1:0]  bcdValue,
    output logic [GW-1:0]        grantId,
    output logic                 busy
);

    localparam int SW = W + BCD_SIZE;
    localparam int CW = $clog2(W + 1);
    localparam int ND = BCD_SIZE / 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [SW-1:0] shiftReg;
    logic [CW-1:0] stepCnt;
    logic [GW-1:0] lastGrant;

    logic [GW-1:0] winner;
    logic [GW-1:0] idx;
    logic          found;
    logic [SW-1:0] corrected;
    logic [SW-1:0] shifted;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((int'(lastGrant) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        corrected = shiftReg;
        for (int d = 0; d < ND; d++) begin
            if (shiftReg[W+4*d +: 4] >= 4'd5) begin
                corrected[W+4*d +: 4] = shiftReg[W+4*d +: 4] + 4'd3;
            end
        end
        shifted = {corrected[SW-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            ack       <= '0;
            bcdValue  <= '0;
            grantId   <= '0;
            busy      <= 1'b0;
            lastGrant <= GW'(NUM_REQ - 1);
            shiftReg  <= '0;
            stepCnt   <= '0;
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        shiftReg  <= {{BCD_SIZE{1'b0}}, hexValue[winner*W +: W]};
                        grantId   <= winner;
                        lastGrant <= winner;
                        stepCnt   <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shiftReg <= shifted;
                    stepCnt  <= stepCnt + 1'b1;
                    if (stepCnt == CW'(W - 1)) begin
                        bcdValue <= shifted[W +: BCD_SIZE];
                        ack      <= NUM_REQ'(1) << grantId;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
